// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state encoding and sizing helpers for the conv2d layer sequencer
package conv_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT_W,
        S_COMMIT_B,
        S_WAIT_IN,
        S_FIRE,
        S_WAIT_CONV,
        S_WAIT_OUT
    } state_t;

    function automatic int conv_num_weights(input int nf, input int ic, input int k);
        return nf * ic * k * k;
    endfunction

    function automatic int conv_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/conv2d_coef_loader.sv
// conv2d_coef_loader: byte counter steering streamed coefficient bytes into the weight then bias registers;
// done fires combinationally with the last accepted byte.
module conv2d_coef_loader
    import conv_pkg::*;
#(
    parameter int NW = 72,
    parameter int NB = 8,
    parameter int AB = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           we,
    input  logic [AB-1:0]  data,
    output logic [NW*AB-1:0] weights,
    output logic [NB*AB-1:0] biases,
    output logic           done
);
    localparam int CW = conv_cnt_width(NW + NB);

    logic [CW-1:0] cnt;

    assign done = we && cnt == CW'(NW + NB - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            weights <= '0;
            biases  <= '0;
        end else begin
            cnt <= (clr || done) ? '0 : (we ? cnt + 1'b1 : cnt);
            if (we && !clr) begin
                if (int'(cnt) < NW)
                    weights[int'(cnt)*AB +: AB] <= data;
                else
                    biases[(int'(cnt) - NW)*AB +: AB] <= data;
            end
        end
    end
endmodule

// File: rtl/conv2d_layer_sequencer.sv
// conv2d_layer_sequencer: loads/commits conv2d coefficients, then gates one feature frame at a time through conv2d.
// Optional CONV2D_SEQ_PERF_EN adds saturating frame_count and stall_count outputs.
module conv2d_layer_sequencer
    import conv_pkg::*;
#(
    parameter int NUM_FILTERS    = 8,
    parameter int INPUT_CHANNELS = 1,
    parameter int KERNEL_SIZE    = 3,
    parameter int ACTIV_BITS     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cfg_start,
    input  logic cfg_valid,
    input  logic [ACTIV_BITS-1:0] cfg_data,
    output logic cfg_ready,
    output logic [conv_num_weights(NUM_FILTERS, INPUT_CHANNELS, KERNEL_SIZE)*ACTIV_BITS-1:0] weights_in,
    output logic [NUM_FILTERS*ACTIV_BITS-1:0] biases_in,
    output logic load_weights,
    output logic load_biases,
    output logic cfg_loaded,
    input  logic in_valid,
    output logic in_ready,
    output logic conv_data_valid,
    input  logic conv_done,
    output logic out_valid,
    input  logic out_ready,
    output logic timeout_err
`ifdef CONV2D_SEQ_PERF_EN
    ,
    output logic [15:0] frame_count,
    output logic [15:0] stall_count
`endif
);
    localparam int NW = conv_num_weights(NUM_FILTERS, INPUT_CHANNELS, KERNEL_SIZE);
    localparam int TW = conv_cnt_width(TIMEOUT_CYCLES);

    state_t        state, state_n;
    logic          start_ok, load_done, timeout;
    logic [TW-1:0] tcnt;

    assign cfg_ready = state == S_LOAD;
    assign in_ready  = state == S_WAIT_IN;
    assign start_ok  = cfg_start && (state == S_IDLE || state == S_WAIT_IN);

    conv2d_coef_loader #(
        .NW(NW),
        .NB(NUM_FILTERS),
        .AB(ACTIV_BITS)
    ) u_loader (
        .clk(clk),
        .rst_n(rst_n),
        .clr(start_ok),
        .we(cfg_ready && cfg_valid),
        .data(cfg_data),
        .weights(weights_in),
        .biases(biases_in),
        .done(load_done)
    );

    always_comb begin
        state_n = state;
        timeout = 1'b0;
        case (state)
            S_IDLE:      state_n = cfg_start ? S_LOAD : S_IDLE;
            S_LOAD:      state_n = load_done ? S_COMMIT_W : S_LOAD;
            S_COMMIT_W:  state_n = S_COMMIT_B;
            S_COMMIT_B:  state_n = S_WAIT_IN;
            S_WAIT_IN:   state_n = cfg_start ? S_LOAD : (in_valid ? S_FIRE : S_WAIT_IN);
            S_FIRE:      state_n = S_WAIT_CONV;
            S_WAIT_CONV: begin
                timeout = !conv_done && tcnt == TW'(TIMEOUT_CYCLES - 1);
                state_n = conv_done ? S_WAIT_OUT : (timeout ? S_WAIT_IN : S_WAIT_CONV);
            end
            S_WAIT_OUT:  state_n = out_ready ? S_WAIT_IN : S_WAIT_OUT;
            default:     state_n = S_IDLE;
        endcase
    end

    // Pulse outputs are registered decodes of the next state, so each is high exactly while in its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            load_weights    <= 1'b0;
            load_biases     <= 1'b0;
            conv_data_valid <= 1'b0;
            out_valid       <= 1'b0;
            cfg_loaded      <= 1'b0;
            timeout_err     <= 1'b0;
            tcnt            <= '0;
        end else begin
            state           <= state_n;
            load_weights    <= state_n == S_COMMIT_W;
            load_biases     <= state_n == S_COMMIT_B;
            conv_data_valid <= state_n == S_FIRE;
            out_valid       <= state_n == S_WAIT_OUT;
            cfg_loaded      <= cfg_loaded || state == S_COMMIT_B;
            timeout_err     <= timeout ? 1'b1 : (start_ok ? 1'b0 : timeout_err);
            tcnt            <= state == S_FIRE ? '0 : (state == S_WAIT_CONV ? tcnt + 1'b1 : tcnt);
        end
    end

`ifdef CONV2D_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
            stall_count <= '0;
        end else begin
            frame_count <= start_ok ? '0 :
                (state == S_WAIT_OUT && out_ready && frame_count != 16'hFFFF) ? frame_count + 1'b1 : frame_count;
            stall_count <= start_ok ? '0 :
                (state == S_WAIT_OUT && !out_ready && stall_count != 16'hFFFF) ? stall_count + 1'b1 : stall_count;
        end
    end
`endif
endmodule

// File: tb/tb_conv2d_layer_sequencer.sv
// tb_conv2d_layer_sequencer: directed self-checking bench for conv2d_layer_sequencer (default 8x1x3x3, 8-bit).
// Define CONV2D_SEQ_PERF_EN to also check the performance counters.
module tb_conv2d_layer_sequencer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_start = 1'b0, cfg_valid = 1'b0;
    logic [7:0]   cfg_data = '0;
    logic         cfg_ready;
    logic [575:0] weights_in;
    logic [63:0]  biases_in;
    logic         load_weights, load_biases, cfg_loaded;
    logic         in_valid = 1'b0, in_ready, conv_data_valid;
    logic         conv_done = 1'b0, out_valid, out_ready = 1'b0, timeout_err;
`ifdef CONV2D_SEQ_PERF_EN
    logic [15:0]  frame_count, stall_count;
`endif
    logic [575:0] ew;
    logic [63:0]  eb;
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    conv2d_layer_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .weights_in(weights_in), .biases_in(biases_in),
        .load_weights(load_weights), .load_biases(load_biases), .cfg_loaded(cfg_loaded),
        .in_valid(in_valid), .in_ready(in_ready), .conv_data_valid(conv_data_valid),
        .conv_done(conv_done), .out_valid(out_valid), .out_ready(out_ready), .timeout_err(timeout_err)
`ifdef CONV2D_SEQ_PERF_EN
        , .frame_count(frame_count), .stall_count(stall_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("start_cfg_ready", 576'(cfg_ready), 576'(1));
    endtask

    task automatic bytes(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                cfg_valid = 1'b0;
                tick();
                tick();
            end
            cfg_valid = 1'b1;
            cfg_data  = 8'(i);
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic commit_check(input string tag);
        chk({tag, "_load_weights"}, 576'(load_weights), 576'(1));
        chk({tag, "_lw_lb_low"}, 576'(load_biases), 576'(0));
        chk({tag, "_cfg_ready_drop"}, 576'(cfg_ready), 576'(0));
        tick();
        chk({tag, "_load_weights_off"}, 576'(load_weights), 576'(0));
        chk({tag, "_load_biases"}, 576'(load_biases), 576'(1));
        tick();
        chk({tag, "_load_biases_off"}, 576'(load_biases), 576'(0));
        chk({tag, "_cfg_loaded"}, 576'(cfg_loaded), 576'(1));
        chk({tag, "_in_ready"}, 576'(in_ready), 576'(1));
        chk({tag, "_weights"}, weights_in, ew);
        chk({tag, "_biases"}, 576'(biases_in), 576'(eb));
    endtask

    task automatic frame_to_out();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("fire_cdv", 576'(conv_data_valid), 576'(1));
        chk("fire_in_ready", 576'(in_ready), 576'(0));
        tick();
        chk("wait_cdv_off", 576'(conv_data_valid), 576'(0));
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        chk("out_valid", 576'(out_valid), 576'(1));
    endtask

    initial begin
        for (int k = 0; k < 72; k++) ew[k*8 +: 8] = 8'(k);
        for (int f = 0; f < 8; f++) eb[f*8 +: 8] = 8'(72 + f);

        // 1: reset then full load
        tick();
        chk("rst_weights", weights_in, '0);
        chk("rst_outs", 576'({cfg_ready, load_weights, load_biases, cfg_loaded, in_ready,
                              conv_data_valid, out_valid, timeout_err}), 576'(0));
        rst_n = 1'b1;
        tick();
        chk("idle_ignores_in_valid", 576'(in_ready), 576'(0));
        start();
        bytes(80, 1'b0);
        commit_check("t1");

        // 2: two back-to-back frames with immediate out_ready
        out_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            frame_to_out();
            tick();
            chk("out_valid_1cyc", 576'(out_valid), 576'(0));
            chk("back_in_wait_in", 576'(in_ready), 576'(1));
        end
`ifdef CONV2D_SEQ_PERF_EN
        chk("frame_count2", 576'(frame_count), 576'(2));
`endif

        // 3 + 5b: backpressure; cfg_start in WAIT_OUT ignored
        out_ready = 1'b0;
        frame_to_out();
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cfg_start = (i == 0);
            tick();
            cfg_start = 1'b0;
            chk("stall_out_valid", 576'(out_valid), 576'(1));
            chk("stall_in_ready", 576'(in_ready), 576'(0));
            chk("stall_no_cdv", 576'(conv_data_valid), 576'(0));
            chk("stall_no_reload", 576'(cfg_ready), 576'(0));
        end
`ifdef CONV2D_SEQ_PERF_EN
        chk("stall_count10", 576'(stall_count), 576'(10));
`endif
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("stall_release", 576'(out_valid), 576'(0));
        chk("stall_release_in_ready", 576'(in_ready), 576'(1));
`ifdef CONV2D_SEQ_PERF_EN
        chk("frame_count3", 576'(frame_count), 576'(3));
`endif

        // 4: conv_done never arrives
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("pre_timeout_err", 576'(timeout_err), 576'(0));
        chk("pre_timeout_in_ready", 576'(in_ready), 576'(0));
        tick();
        chk("timeout_err", 576'(timeout_err), 576'(1));
        chk("timeout_in_ready", 576'(in_ready), 576'(1));
        tick();
        chk("timeout_sticky", 576'(timeout_err), 576'(1));

        // 5: reload from WAIT_IN with gapped bytes
        start();
        chk("reload_clears_timeout", 576'(timeout_err), 576'(0));
        chk("reload_keeps_loaded", 576'(cfg_loaded), 576'(1));
`ifdef CONV2D_SEQ_PERF_EN
        chk("reload_clears_frames", 576'(frame_count), 576'(0));
        chk("reload_clears_stalls", 576'(stall_count), 576'(0));
`endif
        bytes(80, 1'b1);
        commit_check("t5");

        // 6: reset mid-load, then fresh load
        start();
        bytes(40, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_weights", weights_in, '0);
        chk("midrst_biases", 576'(biases_in), 576'(0));
        chk("midrst_outs", 576'({cfg_ready, load_weights, load_biases, cfg_loaded, in_ready,
                                 conv_data_valid, out_valid, timeout_err}), 576'(0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 576'(cfg_ready), 576'(0));
        start();
        bytes(80, 1'b0);
        commit_check("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
